// File: rtl/gps_bridge_pkg.sv
// gps_bridge_pkg: SPI FSM state encodings, derived sizes and parameter legality checks for the GPS-to-MCU bridge
package gps_bridge_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_GAP} spi_state_e;

    function automatic int spw_f(input int word_w, input int nch, input int bits);
        return word_w / (nch * bits);
    endfunction

    function automatic int lvl_w_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // FRAME_WORDS above FIFO_DEPTH is accepted: such a build fills and never transmits
    function automatic bit params_ok(input int word_w, input int nch, input int bits,
                                     input int depth, input int frame_words, input int sck_div);
        return nch > 0 && bits > 0 && word_w >= nch * bits && word_w % (nch * bits) == 0 &&
               depth >= 2 && (depth & (depth - 1)) == 0 && frame_words >= 1 && sck_div >= 1;
    endfunction

endpackage

// File: rtl/gps_word_fifo.sv
// gps_word_fifo: synchronous word FIFO with registered level; push while full is dropped unless a pop frees a slot
module gps_word_fifo
    import gps_bridge_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [lvl_w_f(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w_f(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign level = level_q;
    assign dout  = mem_q[rd_q];

    // Pointer and level bookkeeping; pointers wrap naturally at the power-of-two depth
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    // Storage array carries no reset; only the pointers define valid content
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    // Pointer and level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/gps_spi_packer.sv
// gps_spi_packer: packs GPS sample slices into words, buffers them and streams framed words as an SPI mode-0 master (optional header: GPS_SPI_SEQ_HEADER_EN)
module gps_spi_packer
    import gps_bridge_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int BITS        = 2,
    parameter int WORD_W      = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 4,
    parameter int SCK_DIV     = 2
) (
    input  logic                          MCU_CLK_25_000,
    input  logic                          RESET_P,
    input  logic                          ENABLE,
    input  logic [NCH*BITS-1:0]           SAMPLE_IN,
    input  logic                          SAMPLE_STB,
    input  logic                          OVF_CLR,
    output logic                          MCU_SCK,
    output logic                          MCU_SS,
    output logic                          MCU_MOSI,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
    localparam int SW  = NCH * BITS;
    localparam int SPW = spw_f(WORD_W, NCH, BITS);
    localparam int SLW = $clog2(SPW + 1);
    localparam int BW  = $clog2(WORD_W + 1);
    localparam int CW  = $clog2(2 * SCK_DIV + 1);
`ifdef GPS_SPI_SEQ_HEADER_EN
    localparam int FRAME_LEN = FRAME_WORDS + 1;
`else
    localparam int FRAME_LEN = FRAME_WORDS;
`endif
    localparam int WIW = $clog2(FRAME_LEN + 1);

    if (!params_ok(WORD_W, NCH, BITS, FIFO_DEPTH, FRAME_WORDS, SCK_DIV)) begin : g_bad_params
        $error("gps_spi_packer: illegal parameter combination");
    end

    logic [SLW-1:0]    slot_q, slot_d;
    logic [WORD_W-1:0] word_q, word_d, sh_q, sh_d, fifo_dout;
    logic              push_q, push_d, pop, fifo_full, fifo_empty;
    spi_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WIW-1:0]    wi_q, wi_d;
    logic              ss_q, ss_d, sck_q, sck_d, mosi_q, mosi_d, ovf_q, ovf_d, phase_end;
`ifdef GPS_SPI_SEQ_HEADER_EN
    logic [WORD_W-1:0] seq_q, seq_d;
`endif

    assign MCU_SS   = ss_q;
    assign MCU_SCK  = sck_q;
    assign MCU_MOSI = mosi_q;
    assign OVERFLOW = ovf_q;

    gps_word_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (MCU_CLK_25_000),
        .rst   (RESET_P),
        .push  (push_q),
        .pop   (pop),
        .din   (word_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

    // Shift slices in from the LSB side so the first slice ends up in the MSBs; the full word is pushed next cycle
    always_comb begin
        slot_d = slot_q;
        word_d = word_q;
        push_d = 1'b0;
        if (!ENABLE) slot_d = '0;
        else if (SAMPLE_STB) begin
            word_d = (word_q << SW) | WORD_W'(SAMPLE_IN);
            push_d = slot_q == SLW'(SPW - 1);
            slot_d = push_d ? '0 : slot_q + SLW'(1);
        end
    end

    // SPI frame sequencer; outputs are registered from the next state so they change with the state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        wi_d      = wi_q;
        sh_d      = sh_q;
        phase_end = cnt_q == CW'(SCK_DIV - 1);
        case (state_q)
            S_IDLE: if (int'(FIFO_LEVEL) >= FRAME_WORDS) begin
                state_d = S_LOAD;
                wi_d    = '0;
            end
            S_LOAD: begin
                state_d = S_LOW;
                cnt_d   = '0;
                bit_d   = '0;
            end
            S_LOW: if (phase_end) begin
                state_d = S_HIGH;
                cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
            S_HIGH: if (!phase_end) cnt_d = cnt_q + CW'(1);
            else if (bit_q != BW'(WORD_W - 1)) begin
                state_d = S_LOW;
                cnt_d   = '0;
                bit_d   = bit_q + BW'(1);
                sh_d    = sh_q << 1;
            end else if (wi_q != WIW'(FRAME_LEN - 1)) begin
                state_d = S_LOAD;
                wi_d    = wi_q + WIW'(1);
            end else begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: if (cnt_q == CW'(2 * SCK_DIV - 1)) state_d = S_IDLE;
            else cnt_d = cnt_q + CW'(1);
            default: state_d = S_IDLE;
        endcase
`ifdef GPS_SPI_SEQ_HEADER_EN
        pop = state_d == S_LOAD && wi_d != '0 && !fifo_empty;
        if (state_d == S_LOAD) sh_d = (wi_d == '0) ? seq_q : fifo_dout;
`else
        pop = state_d == S_LOAD && !fifo_empty;
        if (state_d == S_LOAD) sh_d = fifo_dout;
`endif
        ss_d   = !(state_d inside {S_LOAD, S_LOW, S_HIGH});
        sck_d  = state_d == S_HIGH;
        mosi_d = ss_d ? 1'b0 : sh_d[WORD_W-1];
        ovf_d  = (push_q && fifo_full && !pop) ? 1'b1 : OVF_CLR ? 1'b0 : ovf_q;
    end

    // Packer, sequencer and output registers
    always_ff @(posedge MCU_CLK_25_000 or posedge RESET_P) begin
        if (RESET_P) begin
            slot_q  <= '0;
            word_q  <= '0;
            push_q  <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            wi_q    <= '0;
            sh_q    <= '0;
            ss_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            word_q  <= word_d;
            push_q  <= push_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            wi_q    <= wi_d;
            sh_q    <= sh_d;
            ss_q    <= ss_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef GPS_SPI_SEQ_HEADER_EN
    // Frame sequence number advances as each frame completes
    always_comb begin
        seq_d = (state_q == S_HIGH && state_d == S_GAP) ? seq_q + WORD_W'(1) : seq_q;
    end

    // Frame sequence counter register
    always_ff @(posedge MCU_CLK_25_000 or posedge RESET_P) begin
        if (RESET_P) seq_q <= '0;
        else seq_q <= seq_d;
    end
`endif

endmodule

// File: tb/tb_gps_spi_packer.sv
// tb_gps_spi_packer: directed scoreboard bench for gps_spi_packer with an SPI receiver model
module tb_gps_spi_packer;
    localparam int FW       = 4;
    localparam int SCK_DIV  = 2;
    localparam int WORD_CYC = 1 + 16 * 2 * SCK_DIV;
`ifdef GPS_SPI_SEQ_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic       clk, rst, en, stb, clr, stb_o, clr_o;
    logic [3:0] sample;
    logic       sck, ss, mosi, ovf, o_sck, o_ss, o_mosi, o_ovf;
    logic [4:0] level, o_level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    logic        prev_ss, prev_sck, gap_chk;
    int          bits, words, low_cnt, hi_cnt, frames;
    logic [15:0] cap, seq_m;

    gps_spi_packer u_dut (
        .MCU_CLK_25_000 (clk),
        .RESET_P        (rst),
        .ENABLE         (en),
        .SAMPLE_IN      (sample),
        .SAMPLE_STB     (stb),
        .OVF_CLR        (clr),
        .MCU_SCK        (sck),
        .MCU_SS         (ss),
        .MCU_MOSI       (mosi),
        .OVERFLOW       (ovf),
        .FIFO_LEVEL     (level)
    );

    gps_spi_packer #(.FRAME_WORDS(17)) u_ovf (
        .MCU_CLK_25_000 (clk),
        .RESET_P        (rst),
        .ENABLE         (en),
        .SAMPLE_IN      (sample),
        .SAMPLE_STB     (stb_o),
        .OVF_CLR        (clr_o),
        .MCU_SCK        (o_sck),
        .MCU_SS         (o_ss),
        .MCU_MOSI       (o_mosi),
        .OVERFLOW       (o_ovf),
        .FIFO_LEVEL     (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_slice(input logic [3:0] s);
        sample = s;
        stb    = 1'b1;
        tick(1);
        stb    = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        logic [15:0] v;
        v = w;
        exp_q.push_back(w);
        for (int i = 0; i < 4; i++) send_slice(v[15-4*i -: 4]);
    endtask

    task automatic send_o(input logic [15:0] w);
        logic [15:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            sample = v[15-4*i -: 4];
            stb_o  = 1'b1;
            tick(1);
            stb_o  = 1'b0;
        end
    endtask

    task automatic wait_frames(input int n);
        int c;
        c = 0;
        while (frames < n && c < 3000) begin
            tick(1);
            c++;
        end
        chk("frame_count", frames, n);
    endtask

    // SPI receiver model: samples on SCK rising, checks frame length, word count and inter-frame gap
    always @(negedge clk) begin
        if (rst) begin
            bits = 0; words = 0; low_cnt = 0; hi_cnt = 0;
            prev_ss = 1'b1; prev_sck = 1'b0; seq_m = '0;
        end else begin
            if (!ss) begin
                if (prev_ss) begin
                    if (gap_chk) chk("gap_len", hi_cnt, 2 * SCK_DIV + 1);
                    bits = 0; words = 0; low_cnt = 0;
                end
                low_cnt++;
                if (sck && !prev_sck) begin
                    cap = {cap[14:0], mosi};
                    bits++;
                    if (bits == 16) begin
                        if (HDR != 0 && words == 0) chk("header", cap, seq_m);
                        else chk("word", cap, exp_q.size() != 0 ? exp_q.pop_front() : 16'hxxxx);
                        words++;
                        bits = 0;
                    end
                end
            end else begin
                if (!prev_ss) begin
                    chk("ss_low_len", low_cnt, (FW + HDR) * WORD_CYC);
                    chk("frame_words", words, FW + HDR);
                    frames++;
                    seq_m++;
                    hi_cnt = 0;
                end
                hi_cnt++;
                if (sck) chk("sck_idle", sck, 0);
            end
            prev_ss  = ss;
            prev_sck = sck;
        end
    end

    initial begin
        int base, c;
        frames = 0; gap_chk = 1'b0; cap = '0;
        rst = 1'b1; en = 1'b1; stb = 1'b0; clr = 1'b0; stb_o = 1'b0; clr_o = 1'b0; sample = '0;
        tick(2);
        chk("rst_ss", ss, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_level", level, 0);
        chk("rst_o_level", o_level, 0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) send_word(16'hA5F0);
        wait_frames(1);
        tick(20);

        send_slice(4'h1);
        send_slice(4'h2);
        en = 1'b0;
        send_slice(4'h3);
        tick(2);
        en = 1'b1;
        send_word(16'h4567);
        send_word(16'h1234);
        send_word(16'hBEEF);
        send_word(16'h0F0F);
        wait_frames(2);
        tick(20);

        for (int i = 0; i < 8; i++) send_word(16'($urandom_range(0, 65535)));
        wait_frames(3);
        gap_chk = 1'b1;
        wait_frames(4);
        gap_chk = 1'b0;
        chk("queue_after_b2b", exp_q.size(), 0);
        tick(20);

        for (int i = 0; i < 16; i++) send_o(16'h1000 + 16'(i));
        tick(2);
        chk("o_level_full", o_level, 16);
        chk("o_ovf_before", o_ovf, 0);
        send_o(16'hDEAD);
        tick(2);
        chk("o_ovf_set", o_ovf, 1);
        chk("o_level_hold", o_level, 16);
        clr_o = 1'b1;
        tick(1);
        clr_o = 1'b0;
        chk("o_ovf_clr", o_ovf, 0);
        send_o(16'hBEEF);
        clr_o = 1'b1;
        tick(1);
        clr_o = 1'b0;
        chk("o_ovf_clr_vs_drop", o_ovf, 1);
        chk("dut_ovf_quiet", ovf, 0);

        base = frames;
        for (int i = 0; i < 4; i++) send_word(16'h0100 * 16'(i + 1) + 16'h0055);
        c = 0;
        while (!(words == 1 && bits == 8) && c < 2000) begin
            tick(1);
            c++;
        end
        chk("reach_bit7_word2", {16'(words), 16'(bits)}, {16'd1, 16'd8});
        rst = 1'b1;
        #1;
        chk("mid_rst_ss", ss, 1);
        chk("mid_rst_sck", sck, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_o_level", o_level, 0);
        chk("mid_rst_o_ovf", o_ovf, 0);
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        chk("no_completion", frames, base);
        tick(2);
        for (int i = 0; i < 3; i++) send_word(16'h7000 + 16'(i));
        tick(300);
        chk("no_frame_3_words", frames, base);
        chk("ss_idle_3_words", ss, 1);
        send_word(16'h7003);
        wait_frames(base + 1);
        chk("queue_drained", exp_q.size(), 0);
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gps_spi_packer.md
Name: gps_spi_packer

Overview:
- Parametrised successor to the GPS-to-MCU bridge datapath, in the MCU clock domain.
- Accepts already-synchronised multi-channel GPS sample slices on a one-cycle data-ready strobe.
- Packs slices into fixed-width words, buffers words in an internal FIFO, and streams framed words to the MCU as an SPI mode-0 master.
- Adds configurable channel count, sample width, word width, buffering and overflow reporting.

Parameters:
- NCH, 2, number of sample channels (I, Q).
- BITS, 2, bits per channel sample.
- WORD_W, 16, SPI word width; must be a multiple of NCH*BITS.
- FIFO_DEPTH, 16, FIFO depth in words; power of two, at least FRAME_WORDS+1.
- FRAME_WORDS, 4, words sent per SS-low frame.
- SCK_DIV, 2, SCK half-period in clock cycles; at least 1.

Ports:
- MCU_CLK_25_000  in  1  sole clock.
- RESET_P  in  1  asynchronous, active-high reset.
- ENABLE  in  1  capture enable.
- SAMPLE_IN  in  NCH*BITS  slice; channel 0 in the MSBs.
- SAMPLE_STB  in  1  one-cycle strobe: SAMPLE_IN valid.
- OVF_CLR  in  1  one-cycle clear of OVERFLOW.
- MCU_SCK  out  1  SPI clock.
- MCU_SS  out  1  SPI select, active low.
- MCU_MOSI  out  1  SPI data, MSB first.
- OVERFLOW  out  1  sticky: a word was dropped.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  words held.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-frame): MCU_SS=1, MCU_SCK=0, MCU_MOSI=0, OVERFLOW=0, FIFO_LEVEL=0, packer slot=0, SPI FSM=IDLE. A partial frame is abandoned with no completion.
- Packer:
  - SPW = WORD_W/(NCH*BITS) slices per word.
  - Each SAMPLE_STB with ENABLE=1 writes the slice into the next slot, first slice in the MSBs.
  - On the SPW-th slice, the word is pushed to the FIFO on the following cycle.
  - ENABLE=0: strobes are ignored and the slot counter returns to 0; the partial word is discarded.
- FIFO:
  - Push while full: word dropped, OVERFLOW=1 next cycle.
  - OVF_CLR clears OVERFLOW; an overflow in the same cycle wins (OVERFLOW stays 1).
  - Simultaneous push and pop: both take effect, level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO_LEVEL is registered and updates the cycle after a push or pop.
- SPI FSM states: IDLE, LOAD, LOW, HIGH, GAP.
  - IDLE: when FIFO_LEVEL >= FRAME_WORDS, go to LOAD and set MCU_SS=0.
  - LOAD (1 cycle): pop one word into the shift register; MCU_MOSI = word MSB.
  - LOW (SCK_DIV cycles, MCU_SCK=0), then HIGH (SCK_DIV cycles, MCU_SCK=1). MCU samples on the rising edge.
  - On HIGH→LOW the shift register shifts and MCU_MOSI takes the next bit.
  - After bit 0's HIGH phase: if more words remain in the frame, go to LOAD (MCU_SS stays low); otherwise go to GAP.
  - GAP: MCU_SS=1, MCU_SCK=0 for 2*SCK_DIV cycles, then IDLE.
  - Per word: 1 + WORD_W*2*SCK_DIV cycles.
  - A frame is never started with fewer than FRAME_WORDS in the FIFO, so it never underruns.
- ENABLE does not stop a frame already in progress.

Optional Feature:
- Macro: GPS_SPI_SEQ_HEADER_EN.
- Defined:
  - Each frame is preceded by one header word: the low WORD_W bits of a frame sequence counter (reset 0, increments per frame, wraps).
  - The header uses the LOAD/LOW/HIGH timing and is not popped from the FIFO.
  - Frame length is FRAME_WORDS+1 words.
- Undefined: no header, no counter logic.

Decomposition:
- Package gps_bridge_pkg: SPI FSM state encodings, SPW and level-width derived constants, parameter legality checks.
- One sub-module: gps_word_fifo, a synchronous FIFO with push/pop/full/empty/level.
- Packer and SPI FSM stay in the top level.

Test Plan:
- Reset at defaults → MCU_SS=1, MCU_SCK=0, MCU_MOSI=0, OVERFLOW=0, FIFO_LEVEL=0.
- Packing: 16 strobes with slices repeating 4'hA, 4'h5, 4'hF, 4'h0 → one frame of 4 words, each 16'hA5F0 MSB first, SS low for exactly 4*(1+64)=260 cycles, then a 4-cycle gap.
- Overflow: hold MCU_SS path busy (FRAME_WORDS=17 build) and push 17 words → FIFO_LEVEL=16, OVERFLOW=1. OVF_CLR concurrent with another overflowing push → OVERFLOW stays 1.
- ENABLE drop: 2 slices, ENABLE=0, then 4 slices with ENABLE=1 → first word is composed only of the last 4 slices.
- Reset mid-frame: RESET_P pulsed during bit 7 of word 2 → same-cycle MCU_SS=1, MCU_SCK=0, FIFO empty; no output until 4 new words arrive.
- GPS_SPI_SEQ_HEADER_EN defined: two frames → header words 16'h0000 then 16'h0001, each followed by 4 data words under one SS-low.
